// File: rtl/riscv_pkg.sv
// Shared types and default constants for the fetch sequencer of the single-cycle core.
package riscv_pkg;

    localparam int          DEF_XLEN      = 32;
    localparam logic [31:0] DEF_RESET_VEC = 32'h0000_0000;
    localparam logic [31:0] DEF_TRAP_VEC  = 32'h0000_0040;
    localparam int          DEF_PC_STEP   = 1;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_STALL  = 3'd2,
        ST_HALTED = 3'd3
    } fetch_state_e;

endpackage

// File: rtl/pc_next_mux.sv
// Next-PC select for a committing instruction: trap > redirect > sequential step.
module pc_next_mux
    import riscv_pkg::*;
#(
    parameter int               XLEN     = DEF_XLEN,
    parameter logic [XLEN-1:0]  TRAP_VEC = XLEN'(DEF_TRAP_VEC),
    parameter int               PC_STEP  = DEF_PC_STEP
) (
    input  logic [XLEN-1:0] pc,
    input  logic            trap,
    input  logic            redirect,
    input  logic [XLEN-1:0] redirect_target,
    output logic [XLEN-1:0] pc_next
);

    logic [XLEN-1:0] pc_seq;

    // Truncating add: the PC wraps modulo 2^XLEN.
    assign pc_seq = pc + XLEN'(PC_STEP);

    always_comb begin
        pc_next = pc_seq;
        if (trap) begin
            pc_next = TRAP_VEC;
        end else if (redirect) begin
            pc_next = redirect_target;
        end
    end

endmodule

// File: rtl/pc_fetch_ctrl.sv
// Program-counter owner: sequences IDLE/FETCH/STALL/HALTED and issues instruction fetches.
module pc_fetch_ctrl
    import riscv_pkg::*;
#(
    parameter int               XLEN      = DEF_XLEN,
    parameter logic [XLEN-1:0]  RESET_VEC = XLEN'(DEF_RESET_VEC),
    parameter logic [XLEN-1:0]  TRAP_VEC  = XLEN'(DEF_TRAP_VEC),
    parameter int               PC_STEP   = DEF_PC_STEP
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_ready,
    input  logic            stall,
    input  logic            redirect,
    input  logic [XLEN-1:0] redirect_target,
    input  logic            trap,
    input  logic            halt,
    input  logic            resume,
    output logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] epc,
    output logic            commit,
    output logic [XLEN-1:0] retire_cnt,
    output logic [2:0]      state
);

    fetch_state_e    state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] epc_q, epc_d;
    logic [XLEN-1:0] retire_q, retire_d;
    logic [XLEN-1:0] pc_next;

    pc_next_mux #(
        .XLEN     (XLEN),
        .TRAP_VEC (TRAP_VEC),
        .PC_STEP  (PC_STEP)
    ) u_pc_next_mux (
        .pc              (pc_q),
        .trap            (trap),
        .redirect        (redirect),
        .redirect_target (redirect_target),
        .pc_next         (pc_next)
    );

    // imem_req/imem_ready: the instruction at pc transfers on a cycle where both are high
    // (only possible in FETCH); it commits in that same cycle only if stall is also low.
    assign imem_req  = (state_q == ST_FETCH) && !reset;
    assign commit    = imem_req && imem_ready && !stall;
    assign imem_addr = pc_q;
    assign pc        = pc_q;
    assign epc       = epc_q;
    assign retire_cnt = retire_q;
    assign state     = state_q;

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        epc_d    = epc_q;
        retire_d = retire_q;
        unique case (state_q)
            ST_IDLE: begin
                if (start) state_d = ST_FETCH;
            end
            ST_FETCH: begin
                if (imem_ready && stall) begin
                    state_d = ST_STALL;
                end else if (imem_ready) begin
                    pc_d     = pc_next;
                    retire_d = retire_q + XLEN'(1);
                    if (trap) epc_d = pc_q;
                    if (halt) state_d = ST_HALTED;
                end
            end
            ST_STALL: begin
                if (!stall) state_d = ST_FETCH;
            end
            ST_HALTED: begin
                if (resume) state_d = ST_FETCH;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            pc_q     <= RESET_VEC;
            epc_q    <= '0;
            retire_q <= '0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            epc_q    <= epc_d;
            retire_q <= retire_d;
        end
    end

endmodule

// File: doc/pc_fetch_ctrl.md
Name: pc_fetch_ctrl

Overview:
Sequencer that owns the program counter of the single-cycle RISC-V core and drives instruction-memory fetch.
- Decides each cycle whether the PC advances, holds, redirects (branch/jump) or vectors to trap.
- Sits between the instruction memory port and the decode/execute stage; replaces free-running PC increment with a handshaked, stallable, haltable fetch.
- PC is word-indexed: sequential step is 1, not 4.

Parameters:
XLEN, 32, width of PC, addresses and counters
RESET_VEC, 32'h0000_0000, PC loaded on reset
TRAP_VEC, 32'h0000_0040, PC loaded on trap
PC_STEP, 1, sequential increment (word-indexed)

Ports:
clk  in  1  clock, all state updates on rising edge
reset  in  1  asynchronous, active-high reset
start  in  1  leave IDLE and begin fetching
imem_req  out  1  fetch request to instruction memory
imem_addr  out  XLEN  fetch address, always equals pc
imem_ready  in  1  instruction memory returns instruction this cycle
stall  in  1  execute stage cannot accept an instruction
redirect  in  1  taken branch/jump for the committing instruction
redirect_target  in  XLEN  new PC when redirect is honoured
trap  in  1  exception/ecall from the committing instruction
halt  in  1  stop fetching after the committing instruction
resume  in  1  leave HALTED
pc  out  XLEN  current program counter
epc  out  XLEN  PC of the last trapping instruction
commit  out  1  pulse: instruction at pc accepted this cycle
retire_cnt  out  XLEN  number of committed instructions
state  out  3  encoded FSM state, for debug

Behaviour:
- Reset (async, any state, mid-fetch included):
  - pc=RESET_VEC, epc=0, retire_cnt=0, state=IDLE.
  - imem_req=0, commit=0 combinationally while reset is high.
- States: IDLE, FETCH, STALL, HALTED.
- IDLE: imem_req=0. start=1 -> FETCH next cycle; pc unchanged.
- FETCH: imem_req=1, imem_addr=pc.
  - imem_ready=0: hold pc, stay in FETCH, no commit.
  - imem_ready=1 and stall=1: no commit, hold pc, -> STALL.
  - imem_ready=1 and stall=0: commit=1 (same cycle, combinational), retire_cnt+1, next pc selected by priority:
    - trap: pc<=TRAP_VEC, epc<=pc.
    - else redirect: pc<=redirect_target.
    - else: pc<=pc+PC_STEP.
  - Commit with halt=1: pc update as above, then -> HALTED. trap and halt together: trap vector is taken, then HALTED.
- STALL: imem_req=0, pc held. stall=0 -> FETCH; the same pc is refetched. trap/redirect/halt are ignored outside a commit.
- HALTED: imem_req=0, pc held. resume=1 -> FETCH next cycle. start is ignored.
- Arithmetic:
  - pc+PC_STEP is modulo 2^XLEN: 32'hFFFF_FFFF -> 0.
  - retire_cnt wraps modulo 2^XLEN.
  - redirect_target is used unmodified.
- commit is never asserted outside FETCH. Latency from start to first imem_req is 1 cycle.
- Reset deasserting mid-cycle: first edge after deassert evaluates IDLE.

Decomposition:
- Shared package (riscv_pkg):
  - State enum codes: IDLE=0, FETCH=1, STALL=2, HALTED=3.
  - XLEN, RESET_VEC, TRAP_VEC defaults.
- One natural sub-module: pc_next_mux. Combinational priority select trap > redirect > sequential, including the wrap-around adder.
- FSM, pc/epc/retire_cnt registers stay in pc_fetch_ctrl.

Test Plan:
- Reset then start=1, imem_ready=1 for 4 cycles -> pc 0,1,2,3,4; commit high 4 cycles; retire_cnt=4.
- In FETCH at pc=5, imem_ready=1, stall=1 for 3 cycles -> STALL, pc stays 5, no commit. Then stall=0 -> FETCH, refetch addr 5, commit, pc=6.
- Commit at pc=8 with redirect=1, target=32'h20 -> pc=32'h20. Same cycle with trap=1 -> pc=32'h40, epc=8.
- pc preloaded to 32'hFFFF_FFFF via redirect, then sequential commit -> pc=0.
- halt=1 on commit at pc=3 -> pc=4, HALTED, imem_req=0 for 5 cycles. resume=1 -> FETCH, next commit at addr 4.
- Assert reset mid-FETCH with imem_ready=1 -> same cycle pc=RESET_VEC, commit=0, retire_cnt=0, state=IDLE; start ignored until reset low.
